// File: rtl/riscv_fetch_unit_if.sv
// Bus bundle between the fetch unit and its environment (instruction memory,
// core pipeline, branch unit).
//
// Handshake rules:
//   imem: a request transfers when imem_req && imem_gnt at a rising edge; an
//         ungranted request may be withdrawn. Responses (imem_rvalid) come back
//         in request order, at least one cycle after the grant.
//   instr: an instruction transfers when instr_valid && instr_ready at a rising
//         edge; instr_data/instr_pc stay stable while valid and not consumed.
//   redirect: redirect_valid is a one-cycle pulse carrying the new PC.
interface riscv_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, instr_valid, instr_data, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, instr_ready,
           redirect_valid, redirect_pc
  );

  // Environment side (memory, core, branch unit)
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_data, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, instr_ready,
           redirect_valid, redirect_pc
  );
endinterface

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues word fetches under a credit
// limit so the response FIFO can never overflow, buffers in-order responses and
// hands them to the core. A redirect flushes the FIFO and marks every in-flight
// response for discard.
module riscv_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,        // asynchronous, active-low
  riscv_fetch_unit_if.master       bus,
  output logic                     busy,
  output logic [1:0]               dbg_state
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [31:0]   data_mem_q [FIFO_DEPTH];
  logic [31:0]   data_mem_d [FIFO_DEPTH];
  logic [31:0]   pc_mem_q   [FIFO_DEPTH];
  logic [31:0]   pc_mem_d   [FIFO_DEPTH];

  logic          req;
  logic          gnt_hs;
  logic          rv_ok;
  logic          push;
  logic          pop;
  logic [31:0]   rpc_aligned;

  // Request, handshake and FIFO control decode
  always_comb begin
    req         = (state_q == FETCH) && !bus.redirect_valid &&
                  (({1'b0, count_q} + {1'b0, out_q}) < (CW+1)'(FIFO_DEPTH));
    gnt_hs      = req && bus.imem_gnt;
    // A response with nothing outstanding is a bus error and is ignored.
    rv_ok       = bus.imem_rvalid && (out_q != '0);
    push        = rv_ok && !bus.redirect_valid && (disc_q == '0);
    pop         = bus.instr_valid && bus.instr_ready && !bus.redirect_valid;
    rpc_aligned = bus.redirect_pc & 32'hFFFF_FFFC;
  end

  // Next-state computation for PC, counters, FIFO and FSM
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    out_d      = out_q;
    disc_d     = disc_q;
    count_d    = count_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    data_mem_d = data_mem_q;
    pc_mem_d   = pc_mem_q;

    case ({gnt_hs, rv_ok})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase

    if (bus.redirect_valid) begin
      // No grant is possible in a redirect cycle, so out_d is exactly the
      // number of responses still in flight after this edge.
      fetch_pc_d = rpc_aligned;
      rsp_pc_d   = rpc_aligned;
      disc_d     = out_d;
      count_d    = '0;
      wr_d       = '0;
      rd_d       = '0;
      state_d    = (out_d != '0) ? DRAIN : FETCH;
    end else begin
      if (gnt_hs) fetch_pc_d = fetch_pc_q + 32'd4;
      if (rv_ok && (disc_q != '0)) disc_d = disc_q - 1'b1;
      if (push) begin
        data_mem_d[wr_q] = bus.imem_rdata;
        pc_mem_d[wr_q]   = rsp_pc_q;
        wr_d             = wr_q + 1'b1;
        rsp_pc_d         = rsp_pc_q + 32'd4;
      end
      if (pop) rd_d = rd_q + 1'b1;
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      case (state_q)
        BOOT:    state_d = FETCH;
        DRAIN:   state_d = (disc_d == '0) ? FETCH : DRAIN;
        default: state_d = FETCH;
      endcase
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= BOOT;
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_q      <= '0;
      disc_q     <= '0;
      count_q    <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
      count_q    <= count_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      data_mem_q <= data_mem_d;
      pc_mem_q   <= pc_mem_d;
    end
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = fetch_pc_q;
  assign bus.instr_valid = (count_q != '0);
  assign bus.instr_data  = data_mem_q[rd_q];
  assign bus.instr_pc    = pc_mem_q[rd_q];
  assign busy            = (out_q != '0) || (state_q != FETCH);
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Bench for riscv_fetch_unit: an in-order memory model with programmable grant
// and latency, a scoreboard of expected {pc, word} pairs, a redirect vector
// table and hand-written multi-cycle sequences.
module tb_riscv_fetch_unit;

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] a0;
    logic [31:0] a1;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        busy;
  logic [1:0]  dbg_state;

  riscv_fetch_unit_if bus();

  riscv_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst_n),
    .bus       (bus),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          deliv = 0;
  int          lat = 1;
  logic        gnt_en = 1'b0;
  pend_t       pend_q[$];
  logic [31:0] hs_q[$];
  logic [63:0] exp_q[$];
  vec_t        vecs[5];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Expected delivery stream: n consecutive words starting at pc
  task automatic expect_from(input logic [31:0] pc, input int n);
    logic [31:0] p;
    exp_q.delete();
    p = pc;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({p, mem_word(p)});
      p = p + 32'd4;
    end
  endtask

  // One cycle: drive inputs and memory at negedge, sample settled outputs
  task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
    pend_t       p;
    logic [63:0] e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    bus.instr_ready    = rdy;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      p = pend_q.pop_front();
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(p.addr);
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
    end
    bus.imem_gnt = gnt_en;
    #1;
    if (bus.imem_req && bus.imem_gnt) begin
      pend_q.push_back('{addr: bus.imem_addr, due: cyc + lat});
      hs_q.push_back(bus.imem_addr);
    end
    if (bus.instr_valid && bus.instr_ready) begin
      deliv++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected actual=%h required=none", {bus.instr_pc, bus.instr_data});
      end else begin
        e = exp_q.pop_front();
        if ({bus.instr_pc, bus.instr_data} !== e) begin
          errors++;
          $display("FAIL sb_instr actual=%h required=%h", {bus.instr_pc, bus.instr_data}, e);
        end
      end
    end
  endtask

  task automatic wait_hs(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (hs_q.size() < n && k < budget) begin
      step(1'b1, 1'b0, 32'h0);
      k++;
    end
    checks++;
    if (hs_q.size() < n) begin
      errors++;
      $display("FAIL %s timeout actual=%0d required=%0d grants", name, hs_q.size(), n);
    end
  endtask

  initial begin
    vecs[0] = '{rpc: 32'h0000_0100, a0: 32'h0000_0100, a1: 32'h0000_0104};
    vecs[1] = '{rpc: 32'h0000_0203, a0: 32'h0000_0200, a1: 32'h0000_0204};
    vecs[2] = '{rpc: 32'hFFFF_FFFC, a0: 32'hFFFF_FFFC, a1: 32'h0000_0000};
    vecs[3] = '{rpc: 32'h0000_0007, a0: 32'h0000_0004, a1: 32'h0000_0008};
    vecs[4] = '{rpc: 32'hFFFF_FFFF, a0: 32'hFFFF_FFFC, a1: 32'h0000_0000};

    rst_n = 1'b1;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0;
    bus.instr_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0;
    #2 rst_n = 1'b0;

    // Reset state
    gnt_en = 1'b1; lat = 1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
    check("rst_req",   {63'h0, bus.imem_req}, 64'h0);
    check("rst_addr",  {32'h0, bus.imem_addr}, 64'h0);
    check("rst_valid", {63'h0, bus.instr_valid}, 64'h0);
    check("rst_data",  {32'h0, bus.instr_data}, 64'h0);
    check("rst_pc",    {32'h0, bus.instr_pc}, 64'h0);
    check("rst_busy",  {63'h0, busy}, 64'h1);
    check("rst_state", {62'h0, dbg_state}, {62'h0, S_BOOT});

    // Release: streaming fetch from RESET_PC, gnt=1, 1-cycle latency
    rst_n = 1'b1;
    expect_from(32'h0, 64);
    hs_q.delete();
    step(1'b1, 1'b0, 32'h0);
    check("boot_exit_state", {62'h0, dbg_state}, {62'h0, S_FETCH});
    check("boot_exit_req",   {63'h0, bus.imem_req}, 64'h1);
    check("boot_exit_addr",  {32'h0, bus.imem_addr}, 64'h0);
    step(1'b1, 1'b0, 32'h0);
    check("first_valid_early", {63'h0, bus.instr_valid}, 64'h0);
    step(1'b1, 1'b0, 32'h0);
    check("first_valid",     {63'h0, bus.instr_valid}, 64'h1);
    check("first_instr_pc",  {32'h0, bus.instr_pc}, 64'h0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0);
    check("stream_addr0", {32'h0, hs_q[0]}, 64'h0);
    check("stream_addr1", {32'h0, hs_q[1]}, 64'h4);
    check("stream_addr2", {32'h0, hs_q[2]}, 64'h8);

    // Backpressure: credit limit stops requests at FIFO_DEPTH, then resumes
    step(1'b0, 1'b1, 32'h0000_1000);
    expect_from(32'h0000_1000, 64);
    hs_q.delete();
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'h0);
    check("bp_grants",   hs_q.size(), 64'd4);
    check("bp_last",     {32'h0, hs_q[3]}, 64'h100C);
    check("bp_req_off",  {63'h0, bus.imem_req}, 64'h0);
    check("bp_valid",    {63'h0, bus.instr_valid}, 64'h1);
    check("bp_head_pc",  {32'h0, bus.instr_pc}, 64'h1000);
    deliv = 0;
    for (int i = 0; i < 14; i++) step(1'b1, 1'b0, 32'h0);
    check("bp_resume",   {63'h0, hs_q.size() > 4}, 64'h1);
    check("bp_delivered", {63'h0, deliv >= 8}, 64'h1);

    // Redirect with two responses in flight at 3-cycle latency
    gnt_en = 1'b0; lat = 3;
    step(1'b1, 1'b1, 32'h0000_3000);
    expect_from(32'h0000_3000, 64);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0);
    hs_q.delete();
    gnt_en = 1'b1;
    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    gnt_en = 1'b0;
    check("drain_two_grants", hs_q.size(), 64'd2);
    step(1'b1, 1'b1, 32'h0000_0100);
    expect_from(32'h0000_0100, 64);
    hs_q.delete();
    gnt_en = 1'b1;
    step(1'b1, 1'b0, 32'h0);
    check("drain_state", {62'h0, dbg_state}, {62'h0, S_DRAIN});
    check("drain_req",   {63'h0, bus.imem_req}, 64'h0);
    check("drain_valid", {63'h0, bus.instr_valid}, 64'h0);
    check("drain_busy",  {63'h0, busy}, 64'h1);
    deliv = 0;
    wait_hs(1, 20, "drain_refetch");
    check("drain_first_addr", {32'h0, hs_q[0]}, 64'h100);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0);
    check("drain_delivered", {63'h0, deliv > 0}, 64'h1);

    // Redirect in the same cycle as the only outstanding response
    gnt_en = 1'b0;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0);
    lat = 1; gnt_en = 1'b1;
    step(1'b1, 1'b0, 32'h0);
    gnt_en = 1'b0;
    step(1'b1, 1'b1, 32'h0000_0500);
    check("rvredir_busy", {63'h0, busy}, 64'h1);
    expect_from(32'h0000_0500, 64);
    step(1'b1, 1'b0, 32'h0);
    check("rvredir_state", {62'h0, dbg_state}, {62'h0, S_FETCH});
    check("rvredir_valid", {63'h0, bus.instr_valid}, 64'h0);
    check("rvredir_idle",  {63'h0, busy}, 64'h0);
    check("rvredir_addr",  {32'h0, bus.imem_addr}, 64'h500);
    gnt_en = 1'b1; deliv = 0;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0);
    check("rvredir_delivered", {63'h0, deliv > 0}, 64'h1);

    // Redirect table: alignment and address wrap
    for (int v = 0; v < 5; v++) begin
      step(1'b1, 1'b1, vecs[v].rpc);
      expect_from(vecs[v].a0, 64);
      hs_q.delete();
      step(1'b1, 1'b0, 32'h0);
      check("vec_valid_after_redirect", {63'h0, bus.instr_valid}, 64'h0);
      wait_hs(2, 20, "vec_refetch");
      check("vec_addr0", {32'h0, hs_q[0]}, {32'h0, vecs[v].a0});
      check("vec_addr1", {32'h0, hs_q[1]}, {32'h0, vecs[v].a1});
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);
    end

    // Reset mid-operation with FIFO entries and responses in flight
    gnt_en = 1'b0;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);
    lat = 3; gnt_en = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0);
    check("pre_rst_valid", {63'h0, bus.instr_valid}, 64'h1);
    check("pre_rst_busy",  {63'h0, busy}, 64'h1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {63'h0, bus.instr_valid}, 64'h0);
    check("async_rst_req",   {63'h0, bus.imem_req}, 64'h0);
    check("async_rst_addr",  {32'h0, bus.imem_addr}, 64'h0);
    check("async_rst_state", {62'h0, dbg_state}, {62'h0, S_BOOT});
    pend_q.delete();
    bus.imem_rvalid = 1'b0;
    gnt_en = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);
    check("rst_hold_state", {62'h0, dbg_state}, {62'h0, S_BOOT});
    rst_n = 1'b1;
    expect_from(32'h0, 64);
    hs_q.delete();
    lat = 1; gnt_en = 1'b1; deliv = 0;
    wait_hs(1, 10, "rst_refetch");
    check("rst_refetch_addr", {32'h0, hs_q[0]}, 64'h0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0);
    check("rst_delivered", {63'h0, deliv >= 4}, 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
